// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants, bullet FSM states and colour helper
package game_pkg;

    // Image indices
    localparam logic [4:0] DARK     = 5'd31;
    localparam logic [4:0] R_BULLET = 5'd13;
    localparam logic [4:0] G_BULLET = 5'd14;
    localparam logic [4:0] B_BULLET = 5'd15;

    // Display rows
    localparam logic [2:0] BUBBLE_TOP_ROW = 3'd2;
    localparam logic [2:0] BUBBLE_BOT_ROW = 3'd5;
    localparam logic [2:0] SPAWN_ROW      = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLY      = 2'd1,
        ST_LAND     = 2'd2,
        ST_COOLDOWN = 2'd3
    } bullet_state_e;

    // Colour code 3 is not a real colour; fold it onto colour 0.
    function automatic logic [1:0] norm_color(input logic [1:0] c);
        return (c == 2'd3) ? 2'd0 : c;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    // Remember last cycle's level of the input.
    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/bullet_controller.sv
// rtl/bullet_controller.sv - player bullet sequencer; BULLET_COOLDOWN_EN adds post-landing cooldown
module bullet_controller
    import game_pkg::*;
`ifdef BULLET_COOLDOWN_EN
#(
    parameter int COOLDOWN_TICKS = 2
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        run,
    input  logic        fire,
    input  logic [2:0]  player_col,
    input  logic [1:0]  player_color,
    input  logic [31:0] bubble_occ,
    input  logic        land_ack,
    input  logic [3:0]  pop_count,
    output logic        land_req,
    output logic [1:0]  land_row,
    output logic [2:0]  land_col,
    output logic [1:0]  land_color,
    output logic        bullet_vis,
    output logic [2:0]  bullet_row,
    output logic [2:0]  bullet_col,
    output logic [4:0]  bullet_img,
    output logic [3:0]  score_add,
    output logic [7:0]  shots
);

    bullet_state_e state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic [1:0] color_q, color_d;
    logic [1:0] land_row_q, land_row_d;
    logic [2:0] land_col_q, land_col_d;
    logic [1:0] land_color_q, land_color_d;
    logic [3:0] score_q, score_d;
    logic [7:0] shots_q, shots_d;
`ifdef BULLET_COOLDOWN_EN
    logic [3:0] cnt_q, cnt_d;
`endif

    logic fire_rise;

    rise_detect u_fire_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (fire),
        .rise_o (fire_rise)
    );

    // Bubble row of the bullet's own cell and of the cell above it; only
    // meaningful when the corresponding display row lies in the bubble field.
    logic [2:0] above_row;
    logic [1:0] own_br, above_br;
    logic       own_occ, above_occ;

    assign above_row = row_q - 3'd1;
    assign own_br    = row_q[1:0] - 2'd2;
    assign above_br  = row_q[1:0] - 2'd3;
    assign own_occ   = (row_q >= BUBBLE_TOP_ROW) && (row_q <= BUBBLE_BOT_ROW)
                       && bubble_occ[{own_br, col_q}];
    assign above_occ = (above_row >= BUBBLE_TOP_ROW) && (above_row <= BUBBLE_BOT_ROW)
                       && bubble_occ[{above_br, col_q}];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= SPAWN_ROW;
            col_q        <= 3'd0;
            color_q      <= 2'd0;
            land_row_q   <= 2'd0;
            land_col_q   <= 3'd0;
            land_color_q <= 2'd0;
            score_q      <= 4'd0;
            shots_q      <= 8'd0;
`ifdef BULLET_COOLDOWN_EN
            cnt_q        <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            color_q      <= color_d;
            land_row_q   <= land_row_d;
            land_col_q   <= land_col_d;
            land_color_q <= land_color_d;
            score_q      <= score_d;
            shots_q      <= shots_d;
`ifdef BULLET_COOLDOWN_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    // Next-state logic: fire, flight, landing handshake and cooldown.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        color_d      = color_q;
        land_row_d   = land_row_q;
        land_col_d   = land_col_q;
        land_color_d = land_color_q;
        score_d      = 4'd0;
        shots_d      = shots_q;
`ifdef BULLET_COOLDOWN_EN
        cnt_d        = cnt_q;
`endif

        if (!run) begin
            // Leaving the game drops any flight or pending landing silently.
            state_d = ST_IDLE;
`ifdef BULLET_COOLDOWN_EN
            cnt_d   = 4'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fire_rise) begin
                        state_d = ST_FLY;
                        row_d   = SPAWN_ROW;
                        col_d   = player_col;
                        color_d = norm_color(player_color);
                        shots_d = shots_q + 8'd1;
                    end
                end
                ST_FLY: begin
                    if (tick) begin
                        if (row_q == BUBBLE_TOP_ROW) begin
                            state_d      = ST_LAND;
                            land_row_d   = own_br;
                            land_col_d   = col_q;
                            land_color_d = color_q;
                        end else if (own_occ) begin
                            // Bubbles descended onto the bullet.
                            state_d = ST_IDLE;
                        end else if (above_occ) begin
                            if (row_q <= BUBBLE_BOT_ROW) begin
                                state_d      = ST_LAND;
                                land_row_d   = own_br;
                                land_col_d   = col_q;
                                land_color_d = color_q;
                            end else begin
                                // Would stick below the bubble field.
                                state_d = ST_IDLE;
                            end
                        end else begin
                            row_d = above_row;
                        end
                    end
                end
                ST_LAND: begin
                    if (land_ack) begin
                        score_d = pop_count;
`ifdef BULLET_COOLDOWN_EN
                        state_d = ST_COOLDOWN;
                        cnt_d   = 4'd0;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
                ST_COOLDOWN: begin
`ifdef BULLET_COOLDOWN_EN
                    if (tick) begin
                        if (cnt_q == 4'(COOLDOWN_TICKS - 1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign land_req   = (state_q == ST_LAND);
    assign land_row   = land_row_q;
    assign land_col   = land_col_q;
    assign land_color = land_color_q;
    assign bullet_vis = (state_q == ST_FLY) || (state_q == ST_LAND);
    assign bullet_row = row_q;
    assign bullet_col = col_q;
    assign bullet_img = bullet_vis ? (R_BULLET + {3'b000, color_q}) : DARK;
    assign score_add  = score_q;
    assign shots      = shots_q;

endmodule
